// File: rtl/p05_padlock_pkg.sv
`default_nettype none
// =============================================================================
// Module      : p05_padlock_pkg
// Description : Shared types and constants for the padlock input conditioner.
// Revision    : 1.0 - initial release
// =============================================================================
package p05_padlock_pkg;

    localparam int NUM_CH   = 5;
    localparam int NUM_KEYS = 3;

    localparam int KEY_A = 0;
    localparam int KEY_B = 1;
    localparam int KEY_C = 2;
    localparam int CLR   = 3;
    localparam int PROG  = 4;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } ch_state_e;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage : p05_padlock_pkg
`default_nettype wire

// File: rtl/p05_debounce_channel.sv
`default_nettype none
// =============================================================================
// Module      : p05_debounce_channel
// Description : Two-flop synchroniser plus stability-counting debounce FSM.
// Revision    : 1.0 - initial release
// =============================================================================
module p05_debounce_channel
    import p05_padlock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse,
    output logic o_busy
);

    localparam int            CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    ch_state_e     r_state;
    ch_state_e     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_done = (r_cnt == C_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = ST_RISE_WAIT;
                    w_cnt_nxt   = C_ONE;
                end
            end
            ST_RISE_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else if (w_done) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + C_ONE;
                end
            end
            ST_HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_FALL_WAIT;
                    w_cnt_nxt   = C_ONE;
                end
            end
            ST_FALL_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else if (w_done) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + C_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Acceptance is shown in the final WAIT cycle so level and pulse appear
    // after exactly DEBOUNCE_CYCLES cycles of qualification.
    always_comb begin
        o_level = 1'b0;
        o_pulse = 1'b0;
        o_busy  = 1'b0;
        case (r_state)
            ST_LOW: begin
                o_level = 1'b0;
            end
            ST_RISE_WAIT: begin
                o_busy  = 1'b1;
                o_level = r_sync2 & w_done;
                o_pulse = r_sync2 & w_done;
            end
            ST_HIGH: begin
                o_level = 1'b1;
            end
            ST_FALL_WAIT: begin
                o_busy  = 1'b1;
                o_level = ~(~r_sync2 & w_done);
            end
            default: begin
                o_level = 1'b0;
            end
        endcase
    end

endmodule : p05_debounce_channel
`default_nettype wire

// File: rtl/p05_padlock_input_conditioner.sv
`default_nettype none
// =============================================================================
// Module      : p05_padlock_input_conditioner
// Description : Five debounce channels, key press counter and busy flag.
//               Optional macro P05_PADLOCK_MULTIKEY_REJECT_EN suppresses key
//               pulses while more than one key level is high.
// Revision    : 1.0 - initial release
// =============================================================================
module p05_padlock_input_conditioner
    import p05_padlock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       key_raw,
    input  logic             clr_raw,
    input  logic             prog_raw,
    output logic [2:0]       key_level,
    output logic [2:0]       key_pulse,
    output logic             clr_level,
    output logic             prog_level,
    output logic [CNT_W-1:0] press_count,
    output logic             busy
);

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_pulse;
    logic [NUM_CH-1:0] w_busy;
    logic [2:0]        w_key_pulse;
    logic              w_unused_ctrl_pulse;
    logic [CNT_W-1:0]  r_press_count;

    assign w_raw = {prog_raw, clr_raw, key_raw};

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            p05_debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .i_raw   (w_raw[g]),
                .o_level (w_level[g]),
                .o_pulse (w_pulse[g]),
                .o_busy  (w_busy[g])
            );
        end
    endgenerate

    // Control switches qualify as levels only; their strobes are discarded.
    assign w_unused_ctrl_pulse = w_pulse[CLR] | w_pulse[PROG];

`ifdef P05_PADLOCK_MULTIKEY_REJECT_EN
    assign w_key_pulse = (popcount3(w_level[KEY_C:KEY_A]) > 2'd1) ? 3'b000
                                                                 : w_pulse[KEY_C:KEY_A];
`else
    assign w_key_pulse = w_pulse[KEY_C:KEY_A];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press_count <= '0;
        end else begin
            r_press_count <= r_press_count + CNT_W'(popcount3(w_key_pulse));
        end
    end

    assign key_level   = w_level[KEY_C:KEY_A];
    assign key_pulse   = w_key_pulse;
    assign clr_level   = w_level[CLR];
    assign prog_level  = w_level[PROG];
    assign press_count = r_press_count;
    assign busy        = |w_busy;

endmodule : p05_padlock_input_conditioner
`default_nettype wire

// File: tb/tb_p05_padlock_input_conditioner.sv
`default_nettype none
// =============================================================================
// Module      : tb_p05_padlock_input_conditioner
// Description : Randomised bench comparing two conditioner instances
//               (DEBOUNCE_CYCLES 4 and 1) against a run-length reference model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_p05_padlock_input_conditioner;

    localparam int CNT_W = 8;
    localparam int NDUT  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key_raw;
    logic       clr_raw;
    logic       prog_raw;

    logic [2:0]       key_level   [NDUT];
    logic [2:0]       key_pulse   [NDUT];
    logic             clr_level   [NDUT];
    logic             prog_level  [NDUT];
    logic [CNT_W-1:0] press_count [NDUT];
    logic             busy        [NDUT];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    p05_padlock_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(CNT_W)) u_dut4 (
        .clk (clk), .rst (rst), .key_raw (key_raw), .clr_raw (clr_raw), .prog_raw (prog_raw),
        .key_level (key_level[0]), .key_pulse (key_pulse[0]), .clr_level (clr_level[0]),
        .prog_level (prog_level[0]), .press_count (press_count[0]), .busy (busy[0])
    );

    p05_padlock_input_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(CNT_W)) u_dut1 (
        .clk (clk), .rst (rst), .key_raw (key_raw), .clr_raw (clr_raw), .prog_raw (prog_raw),
        .key_level (key_level[1]), .key_pulse (key_pulse[1]), .clr_level (clr_level[1]),
        .prog_level (prog_level[1]), .press_count (press_count[1]), .busy (busy[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a switch flips once its synchronised value has disagreed
    // with the accepted level for DEBOUNCE_CYCLES+1 consecutive cycles.
    bit [4:0] s1, s2;
    int       run      [NDUT][5];
    bit       lvl      [NDUT][5];
    bit       acc      [NDUT][5];
    bit       wait_nxt [NDUT][5];
    int       pc       [NDUT];
    int       prev_pop [NDUT];
    bit [4:0] e_lvl    [NDUT];
    bit [2:0] e_kp     [NDUT];
    bit       e_busy   [NDUT];
    int       presses_since_reset;

    function automatic int deb(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic model_reset();
        s1 = '0;
        s2 = '0;
        for (int d = 0; d < NDUT; d++) begin
            pc[d]       = 0;
            prev_pop[d] = 0;
            for (int c = 0; c < 5; c++) begin
                run[d][c]      = 0;
                lvl[d][c]      = 1'b0;
                acc[d][c]      = 1'b0;
                wait_nxt[d][c] = 1'b0;
            end
        end
        presses_since_reset = 0;
    endtask

    task automatic model_step();
        bit [4:0] raw;
        bit [4:0] rise;
        raw = {prog_raw, clr_raw, key_raw};
        s2  = s1;
        s1  = raw;
        for (int d = 0; d < NDUT; d++) begin
            pc[d]     = (pc[d] + prev_pop[d]) % (1 << CNT_W);
            e_busy[d] = 1'b0;
            rise      = '0;
            for (int c = 0; c < 5; c++) begin
                e_busy[d] = e_busy[d] | wait_nxt[d][c];
                if (acc[d][c]) begin
                    lvl[d][c] = ~lvl[d][c];
                    run[d][c] = 0;
                end
                if (s2[c] != lvl[d][c]) run[d][c]++;
                else                    run[d][c] = 0;
                acc[d][c]      = (run[d][c] == deb(d) + 1);
                e_lvl[d][c]    = lvl[d][c] ^ acc[d][c];
                rise[c]        = acc[d][c] & ~lvl[d][c];
                wait_nxt[d][c] = (run[d][c] >= 1) && !acc[d][c];
            end
            e_kp[d] = rise[2:0];
`ifdef P05_PADLOCK_MULTIKEY_REJECT_EN
            if ($countones(e_lvl[d][2:0]) > 1) e_kp[d] = 3'b000;
`endif
            prev_pop[d] = $countones(e_kp[d]);
            if (d == 0) presses_since_reset += prev_pop[d];
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d.key_level", d),   32'(key_level[d]),   32'(e_lvl[d][2:0]));
            check($sformatf("d%0d.key_pulse", d),   32'(key_pulse[d]),   32'(e_kp[d]));
            check($sformatf("d%0d.clr_level", d),   32'(clr_level[d]),   32'(e_lvl[d][3]));
            check($sformatf("d%0d.prog_level", d),  32'(prog_level[d]),  32'(e_lvl[d][4]));
            check($sformatf("d%0d.press_count", d), 32'(press_count[d]), 32'(pc[d]));
            check($sformatf("d%0d.busy", d),        32'(busy[d]),        32'(e_busy[d]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s.d%0d.key_level", tag, d),   32'(key_level[d]),   32'd0);
            check($sformatf("%s.d%0d.key_pulse", tag, d),   32'(key_pulse[d]),   32'd0);
            check($sformatf("%s.d%0d.clr_level", tag, d),   32'(clr_level[d]),   32'd0);
            check($sformatf("%s.d%0d.prog_level", tag, d),  32'(prog_level[d]),  32'd0);
            check($sformatf("%s.d%0d.press_count", tag, d), 32'(press_count[d]), 32'd0);
            check($sformatf("%s.d%0d.busy", tag, d),        32'(busy[d]),        32'd0);
        end
    endtask

    // Reset is asserted mid-cycle so its asynchronous effect is visible at once.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs(tag);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int  hold;
    bit  wrapped;

    initial begin
        rst      = 1'b1;
        key_raw  = 3'b000;
        clr_raw  = 1'b0;
        prog_raw = 1'b0;
        hold     = 0;
        wrapped  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;

        for (int cyc = 0; cyc < 9000; cyc++) begin
            @(posedge clk);
            #1;
            model_step();
            compare_all();
            if (presses_since_reset >= 256) wrapped = 1'b1;

            if (cyc >= 6000 && $urandom_range(0, 119) == 0) begin
                do_reset("rst_mid");
            end else if (hold == 0) begin
                // Mix long holds (accepted) with short glitches (rejected bounce).
                if ($urandom_range(0, 3) == 0) hold = $urandom_range(1, 3);
                else                           hold = $urandom_range(6, 14);
                key_raw  = 3'($urandom_range(0, 7));
                clr_raw  = 1'($urandom_range(0, 1));
                prog_raw = 1'($urandom_range(0, 1));
            end else begin
                hold--;
            end
        end

        check("wrap_reached", 32'(wrapped), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_p05_padlock_input_conditioner
`default_nettype wire

// File: doc/p05_padlock_input_conditioner.md
# p05_padlock_input_conditioner

Input conditioning stage that sits directly upstream of the p05 padlock core. It takes the raw asynchronous switch inputs (three code keys, clear, program-mode) and synchronises and debounces each one. It presents clean levels to the padlock core and emits single-cycle rising-edge strobes for the code keys. It also maintains a wrap-around count of accepted key presses for status display.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive stable synchronised cycles required before a level change is accepted; legal range 1..255.
- CNT_W, default 8: width of press_count.

Ports:
- clk  in  1  single clock domain for all state.
- rst  in  1  reset, asynchronous and active-high; clears all state.
- key_raw  in  3  raw code keys (bit0 = key A, bit1 = key B, bit2 = key C); asynchronous.
- clr_raw  in  1  raw clear switch; asynchronous.
- prog_raw  in  1  raw program-mode switch; asynchronous.
- key_level  out  3  debounced key levels, feeding the padlock core code inputs.
- key_pulse  out  3  one-cycle strobe on each accepted key rising edge.
- clr_level  out  1  debounced clear.
- prog_level  out  1  debounced program mode.
- press_count  out  CNT_W  count of accepted key presses; wraps.
- busy  out  1  high while any channel is in a WAIT state.

## Operation
- Five identical channels, one each for key[0..2], clr and prog.
- Each channel has a two-flop synchroniser, then a 4-state FSM with a stability counter. Counter width is $clog2(DEBOUNCE_CYCLES+1).
- FSM states and transitions:
  - LOW: sync=1 → RISE_WAIT, counter=1.
  - RISE_WAIT: sync=1 and counter==DEBOUNCE_CYCLES → HIGH, level=1, pulse=1 for one cycle. sync=1 otherwise → counter+1. sync=0 → LOW, counter=0 (bounce rejected).
  - HIGH: sync=0 → FALL_WAIT, counter=1.
  - FALL_WAIT: mirror of RISE_WAIT. Acceptance → LOW, level=0, no pulse. Bounce → HIGH.
- With DEBOUNCE_CYCLES=1, acceptance occurs on the first cycle spent in the WAIT state.
- press_count increments by popcount(key_pulse) each cycle: 0..3 added in a single cycle. Modulo 2^CNT_W, so 255+1 → 0 at CNT_W=8.
- clr and prog channels never pulse and never affect press_count.
- busy is the OR of all channels being in RISE_WAIT or FALL_WAIT.

## Timing
- Reset (asynchronous assert): synchronisers 0, all FSMs LOW, counters 0, all outputs 0, press_count 0, busy 0. Deassertion is taken synchronously to clk by the integrating top level.
- Reset mid-debounce abandons the pending transition. A key still held after reset is re-qualified from LOW.
- Latency, raw rise to key_level/key_pulse: 2 sync cycles + DEBOUNCE_CYCLES cycles, counted from the first edge sampling the new value. This is 6 edges for the default.
- Falling-edge latency is identical.
- key_pulse is high for exactly one cycle, in the same cycle key_level first reads 1.
- press_count updates one cycle after the pulse is visible.
- Channels are fully independent. Simultaneous rises accepted in the same cycle produce simultaneous pulses.

## Configuration
- P05_PADLOCK_MULTIKEY_REJECT_EN defined:
  - If more than one key_level would be high in the cycle a key pulse is generated, that pulse is suppressed and press_count is not incremented.
  - key_level still updates normally.
- Macro undefined: all pulses pass independently, as described above.

## Structure
- Package p05_padlock_pkg holds:
  - the channel FSM state enum (LOW, RISE_WAIT, HIGH, FALL_WAIT);
  - channel index constants (KEY_A=0, KEY_B=1, KEY_C=2, CLR=3, PROG=4);
  - NUM_CH=5.
- Sub-module p05_debounce_channel: synchroniser, FSM, counter and level/pulse outputs, parameterised by DEBOUNCE_CYCLES. The top level instantiates it five times and adds the press counter, busy OR and the multikey gate.

## Test plan
All with DEBOUNCE_CYCLES=4 unless stated.
- Clean press: key_raw=001 held 10 cycles → key_pulse[0]=1 for exactly one cycle at edge 6, key_level[0]=1, press_count 0→1.
- Bounce: key_raw[1] toggles 1,0,1,0 on successive cycles, then 0 → no pulse, key_level[1] stays 0, busy high during the toggles then 0, press_count unchanged.
- Release: hold key C 10 cycles, then release → key_level[2] falls 6 edges after release, no pulse on the fall.
- Simultaneous press, macro off: key_raw 000→011 → two pulses in the same cycle, press_count +2. Macro on: pulses suppressed, press_count +0.
- Wrap: 256 accepted presses from reset → press_count returns to 0.
- Reset mid-operation: assert rst during RISE_WAIT with key held → all outputs 0 immediately. After release of rst with the key still held, pulse appears 6 edges later. Repeat with DEBOUNCE_CYCLES=1 → pulse at edge 3.
